// File: rtl/riscv_pc_pkg.sv
// Shared types and constants for the fetch program-counter generator.
package riscv_pc_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } pc_state_e;

  localparam int STEP_16 = 2;
  localparam int STEP_32 = 4;

  // Low PC bits that must be zero for the given instruction alignment.
  function automatic logic [1:0] align_mask(input int ialign);
    return (ialign == 16) ? 2'b01 : 2'b11;
  endfunction

endpackage

// File: rtl/riscv_pc_next_sel.sv
// Next-PC priority mux (trap > redirect > sequential > hold) with alignment fix-up.
module riscv_pc_next_sel
  import riscv_pc_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int IALIGN = 32
) (
  input  logic [XLEN-1:0] fetch_pc,
  input  logic            accept,
  input  logic            step_c,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            redirect_req,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] next_pc,
  output logic            misalign
);

  localparam logic [1:0]      LOW_MASK  = align_mask(IALIGN);
  localparam logic [XLEN-1:0] KEEP_MASK = {{(XLEN-2){1'b1}}, ~LOW_MASK};

  logic [XLEN-1:0] target;
  logic [XLEN-1:0] step;
  logic [XLEN-1:0] seq_pc;

  always_comb begin
    target   = trap_req ? trap_pc : redirect_pc;
    step     = ((IALIGN == 16) && step_c) ? XLEN'(STEP_16) : XLEN'(STEP_32);
    seq_pc   = fetch_pc + step;
    next_pc  = fetch_pc;
    misalign = 1'b0;
    // Loaded targets are forced legal; only loads can flag misalignment.
    if (trap_req || redirect_req) begin
      next_pc  = target & KEEP_MASK;
      misalign = |(target[1:0] & LOW_MASK);
    end else if (accept) begin
      next_pc = seq_pc;
    end
  end

endmodule

// File: rtl/riscv_pc_gen.sv
// Fetch PC generator: BOOT/RUN/HALTED control, registered PC, misalign pulse
// and accepted-fetch counter.
module riscv_pc_gen
  import riscv_pc_pkg::*;
#(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              IALIGN       = 32,
  parameter int              CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_ready_i,
  input  logic             step_c_i,
  input  logic             redirect_valid_i,
  input  logic [XLEN-1:0]  redirect_pc_i,
  input  logic             trap_valid_i,
  input  logic [XLEN-1:0]  trap_pc_i,
  input  logic             halt_i,
  input  logic             resume_i,
  output logic             fetch_valid_o,
  output logic [XLEN-1:0]  fetch_pc_o,
  output logic             halted_o,
  output logic             misalign_o,
  output logic [CNT_W-1:0] fetch_cnt_o,
  output pc_state_e        state_o
);

  // Handshake: an offer (fetch_valid_o, fetch_pc_o) is consumed on a clock
  // edge where fetch_valid_o & fetch_ready_i; valid never depends on ready,
  // and the offer holds until consumed unless a trap/redirect replaces it.

  pc_state_e       state_q, state_d;
  logic            accept;
  logic            trap_req;
  logic            redirect_req;
  logic [XLEN-1:0] next_pc;
  logic            misalign;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= BOOT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (halt_i) state_d = HALTED;
      HALTED:  if (resume_i && !halt_i) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    fetch_valid_o = (state_q == RUN);
    halted_o      = (state_q == HALTED);
    state_o       = state_q;
  end

  // A halted core still takes debugger PC writes but ignores traps.
  assign accept       = fetch_valid_o & fetch_ready_i;
  assign trap_req     = trap_valid_i & (state_q == RUN);
  assign redirect_req = redirect_valid_i & (state_q != BOOT);

  riscv_pc_next_sel #(
    .XLEN   (XLEN),
    .IALIGN (IALIGN)
  ) u_next_sel (
    .fetch_pc     (fetch_pc_o),
    .accept       (accept),
    .step_c       (step_c_i),
    .trap_req     (trap_req),
    .trap_pc      (trap_pc_i),
    .redirect_req (redirect_req),
    .redirect_pc  (redirect_pc_i),
    .next_pc      (next_pc),
    .misalign     (misalign)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_o  <= RESET_VECTOR;
      misalign_o  <= 1'b0;
      fetch_cnt_o <= '0;
    end else begin
      fetch_pc_o <= next_pc;
      misalign_o <= misalign;
      if (accept) fetch_cnt_o <= fetch_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_riscv_pc_gen.sv
// Directed bench for riscv_pc_gen: IALIGN=32 and IALIGN=16 instances share
// stimulus and are each checked against a spec-level model every cycle.
module tb_riscv_pc_gen;
  import riscv_pc_pkg::*;

  localparam logic [63:0] RV = 64'h8000_0000;

  logic        clk, rst;
  logic        fetch_ready_i, step_c_i, redirect_valid_i, trap_valid_i;
  logic        halt_i, resume_i;
  logic [63:0] redirect_pc_i, trap_pc_i;

  logic        v32, h32, m32, v16, h16, m16;
  logic [63:0] pc32, pc16;
  logic [31:0] cnt32, cnt16;
  pc_state_e   st32, st16;

  int checks = 0;
  int errors = 0;

  riscv_pc_gen #(.XLEN(64), .RESET_VECTOR(RV), .IALIGN(32), .CNT_W(32)) dut32 (
    .clk(clk), .rst(rst), .fetch_ready_i(fetch_ready_i), .step_c_i(step_c_i),
    .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
    .trap_valid_i(trap_valid_i), .trap_pc_i(trap_pc_i), .halt_i(halt_i),
    .resume_i(resume_i), .fetch_valid_o(v32), .fetch_pc_o(pc32),
    .halted_o(h32), .misalign_o(m32), .fetch_cnt_o(cnt32), .state_o(st32)
  );

  riscv_pc_gen #(.XLEN(64), .RESET_VECTOR(RV), .IALIGN(16), .CNT_W(32)) dut16 (
    .clk(clk), .rst(rst), .fetch_ready_i(fetch_ready_i), .step_c_i(step_c_i),
    .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
    .trap_valid_i(trap_valid_i), .trap_pc_i(trap_pc_i), .halt_i(halt_i),
    .resume_i(resume_i), .fetch_valid_o(v16), .fetch_pc_o(pc16),
    .halted_o(h16), .misalign_o(m16), .fetch_cnt_o(cnt16), .state_o(st16)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  // mode: 0 = boot, 1 = running, 2 = halted
  typedef struct packed {
    logic [1:0]  mode;
    logic [63:0] pc;
    logic [31:0] cnt;
    logic        mis;
  } mstate_t;

  mstate_t mdl32, mdl16;

  function automatic mstate_t model_step(input mstate_t cur, input bit c16);
    mstate_t     n;
    logic [63:0] t;
    logic [63:0] bad;
    bit          load;
    n     = cur;
    n.mis = 1'b0;
    load  = 1'b0;
    t     = '0;
    if (cur.mode == 2'd0) begin
      n.mode = 2'd1;
    end else if (cur.mode == 2'd1) begin
      if (fetch_ready_i) n.cnt = cur.cnt + 32'd1;
      if (trap_valid_i) begin
        load = 1'b1; t = trap_pc_i;
      end else if (redirect_valid_i) begin
        load = 1'b1; t = redirect_pc_i;
      end else if (fetch_ready_i) begin
        n.pc = cur.pc + ((c16 && step_c_i) ? 64'd2 : 64'd4);
      end
      if (halt_i) n.mode = 2'd2;
    end else begin
      if (redirect_valid_i) begin
        load = 1'b1; t = redirect_pc_i;
      end
      if (resume_i && !halt_i) n.mode = 2'd1;
    end
    if (load) begin
      bad   = c16 ? (t % 64'd2) : (t % 64'd4);
      n.pc  = t - bad;
      n.mis = (bad != 64'd0);
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdl32 <= '{mode: 2'd0, pc: RV, cnt: 32'd0, mis: 1'b0};
      mdl16 <= '{mode: 2'd0, pc: RV, cnt: 32'd0, mis: 1'b0};
    end else begin
      mdl32 <= model_step(mdl32, 1'b0);
      mdl16 <= model_step(mdl16, 1'b1);
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("valid32",  64'(v32),   64'(mdl32.mode == 2'd1));
    chk("halted32", 64'(h32),   64'(mdl32.mode == 2'd2));
    chk("state32",  64'(st32),  64'(mdl32.mode));
    chk("pc32",     pc32,       mdl32.pc);
    chk("cnt32",    64'(cnt32), 64'(mdl32.cnt));
    chk("mis32",    64'(m32),   64'(mdl32.mis));
    chk("valid16",  64'(v16),   64'(mdl16.mode == 2'd1));
    chk("halted16", 64'(h16),   64'(mdl16.mode == 2'd2));
    chk("state16",  64'(st16),  64'(mdl16.mode));
    chk("pc16",     pc16,       mdl16.pc);
    chk("cnt16",    64'(cnt16), 64'(mdl16.cnt));
    chk("mis16",    64'(m16),   64'(mdl16.mis));
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_req();
    redirect_valid_i = 1'b0;
    trap_valid_i     = 1'b0;
    halt_i           = 1'b0;
    resume_i         = 1'b0;
  endtask

  task automatic load_pc(input logic [63:0] pc);
    fetch_ready_i    = 1'b0;
    redirect_valid_i = 1'b1;
    redirect_pc_i    = pc;
    tick();
    clear_req();
  endtask

  initial begin
    rst = 1'b1;
    fetch_ready_i = 1'b1; step_c_i = 1'b0;
    redirect_pc_i = '0; trap_pc_i = '0;
    clear_req();
    tick(); tick();

    // reset release and first fetches
    rst = 1'b0;
    chk("lit_boot_valid", 64'(v32), 64'd0);
    tick();
    chk("lit_first_pc", pc32, 64'h8000_0000);
    chk("lit_first_valid", 64'(v32), 64'd1);
    tick();
    chk("lit_pc_plus4", pc32, 64'h8000_0004);
    chk("lit_cnt1", 64'(cnt32), 64'd1);
    tick();
    chk("lit_pc_plus8", pc32, 64'h8000_0008);
    chk("lit_cnt2", 64'(cnt32), 64'd2);

    // compressed stepping
    load_pc(64'h100);
    fetch_ready_i = 1'b1;
    step_c_i = 1'b1; tick();
    chk("lit_c16_a", pc16, 64'h102);
    chk("lit_c32_a", pc32, 64'h104);
    step_c_i = 1'b0; tick();
    chk("lit_c16_b", pc16, 64'h106);
    step_c_i = 1'b1; tick();
    chk("lit_c16_c", pc16, 64'h108);
    step_c_i = 1'b0;

    // priority and flush of an unaccepted offer
    load_pc(64'h200);
    tick();
    chk("lit_hold", pc32, 64'h200);
    trap_valid_i = 1'b1; trap_pc_i = 64'h1000;
    redirect_valid_i = 1'b1; redirect_pc_i = 64'h300;
    tick(); clear_req();
    chk("lit_trap_wins", pc32, 64'h1000);
    redirect_valid_i = 1'b1; redirect_pc_i = 64'h300;
    tick(); clear_req();
    chk("lit_redirect", pc16, 64'h300);
    fetch_ready_i = 1'b1; trap_valid_i = 1'b1; trap_pc_i = 64'h2000;
    tick(); clear_req();

    // misaligned redirect
    load_pc(64'h403);
    chk("lit_mis32_pc", pc32, 64'h400);
    chk("lit_mis16_pc", pc16, 64'h402);
    chk("lit_mis32", 64'(m32), 64'd1);
    tick();
    chk("lit_mis32_drop", 64'(m32), 64'd0);
    load_pc(64'h401);

    // halt / resume
    load_pc(64'h500);
    fetch_ready_i = 1'b1; halt_i = 1'b1;
    tick(); clear_req();
    chk("lit_halt_pc", pc32, 64'h504);
    chk("lit_halted", 64'(h32), 64'd1);
    redirect_valid_i = 1'b1; redirect_pc_i = 64'h600;
    trap_valid_i = 1'b1; trap_pc_i = 64'h700;
    tick(); clear_req();
    chk("lit_dbg_write", pc32, 64'h600);
    halt_i = 1'b1; resume_i = 1'b1;
    tick(); clear_req();
    chk("lit_still_halted", 64'(h16), 64'd1);
    resume_i = 1'b1;
    tick(); clear_req();
    chk("lit_resumed", 64'(v32), 64'd1);
    tick();

    // wrap
    load_pc(64'hFFFF_FFFF_FFFF_FFFC);
    fetch_ready_i = 1'b1;
    tick();
    chk("lit_wrap", pc32, 64'h0);

    // mid-operation reset with pending redirect
    fetch_ready_i = 1'b0;
    redirect_valid_i = 1'b1; redirect_pc_i = 64'h800;
    rst = 1'b1;
    #1;
    chk("lit_rst_pc", pc32, RV);
    chk("lit_rst_state", 64'(st32), 64'(BOOT));
    chk("lit_rst_cnt", 64'(cnt16), 64'd0);
    tick();
    clear_req();
    rst = 1'b0;
    fetch_ready_i = 1'b1;
    tick(); tick();
    chk("lit_after_rst", pc32, RV + 64'd4);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
